// File: rtl/parking_gate_sensor.sv
// parking_gate_sensor
//   Turns the raw outer/inner photo-beam pair of one parking-lot lane into
//   one-cycle entrance/exit pulses for the occupancy datapath. Each beam is
//   synchronized (two flops) and optionally debounced. A direction-tracking
//   FSM then pulses only after a complete, ordered traversal of both beams.
//
// Build option:
//   PARKING_SENSOR_DEBOUNCE_EN  defined   -> debounce stage present, DEBOUNCE honored
//                               undefined -> filtered beam = synchronized beam
//
// Parameters:
//   DEBOUNCE       consecutive synchronized cycles a new beam value must hold (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   sensor_outer   raw street-side beam, 1 = blocked (asynchronous)
//   sensor_inner   raw lot-side beam, 1 = blocked (asynchronous)
//   entrance_gate  one-cycle pulse: completed entry
//   exit_gate      one-cycle pulse: completed exit
//   fault          one-cycle pulse on entry into the fault state
//   busy           high while the FSM is (about to be) outside IDLE
module parking_gate_sensor #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_outer,
  input  logic sensor_inner,
  output logic entrance_gate,
  output logic exit_gate,
  output logic fault,
  output logic busy
);

  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("parking_gate_sensor: DEBOUNCE must be >= 1");
  end

  // Bit 1 = outer beam, bit 0 = inner beam throughout.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sensor_outer, sensor_inner};
      sync2 <= sync1;
    end
  end

`ifdef PARKING_SENSOR_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt [2];

  // Counter tracks how long sync has disagreed with the filtered bit; the
  // filtered bit flips on the DEBOUNCE-th consecutive disagreeing edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, FAULT
  } state_t;

  state_t state;
  state_t nxt;
  logic   go_ent;
  logic   go_ext;

  always_comb begin
    nxt    = state;
    go_ent = 1'b0;
    go_ext = 1'b0;
    case (state)
      IDLE:
        case (filt)
          2'b10:   nxt = IN1;
          2'b01:   nxt = OUT1;
          2'b11:   nxt = FAULT;
          default: ;
        endcase
      IN1:
        case (filt)
          2'b11:   nxt = IN2;
          2'b00:   nxt = IDLE;
          2'b01:   nxt = FAULT;
          default: ;
        endcase
      IN2:
        case (filt)
          2'b01:   nxt = IN3;
          2'b10:   nxt = IN1;
          2'b00:   nxt = FAULT;
          default: ;
        endcase
      IN3:
        case (filt)
          2'b00: begin
            nxt    = IDLE;
            go_ent = 1'b1;
          end
          2'b11:   nxt = IN2;
          2'b10:   nxt = FAULT;
          default: ;
        endcase
      OUT1:
        case (filt)
          2'b11:   nxt = OUT2;
          2'b00:   nxt = IDLE;
          2'b10:   nxt = FAULT;
          default: ;
        endcase
      OUT2:
        case (filt)
          2'b10:   nxt = OUT3;
          2'b01:   nxt = OUT1;
          2'b00:   nxt = FAULT;
          default: ;
        endcase
      OUT3:
        case (filt)
          2'b00: begin
            nxt    = IDLE;
            go_ext = 1'b1;
          end
          2'b11:   nxt = OUT2;
          2'b01:   nxt = FAULT;
          default: ;
        endcase
      FAULT:
        if (filt == 2'b00) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      entrance_gate <= 1'b0;
      exit_gate     <= 1'b0;
      fault         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= nxt;
      entrance_gate <= go_ent;
      exit_gate     <= go_ext;
      // FAULT self-loops on any non-00 pair, so pulse only on the way in.
      fault         <= (nxt == FAULT) && (state != FAULT);
      busy          <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_parking_gate_sensor.sv
module tb_parking_gate_sensor;

  localparam int unsigned DB = 2;
`ifdef PARKING_SENSOR_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic so = 1'b0;
  logic si = 1'b0;
  logic entrance_gate, exit_gate, fault, busy;

  always #5 clk = ~clk;

  parking_gate_sensor #(.DEBOUNCE(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_outer (so),
    .sensor_inner (si),
    .entrance_gate(entrance_gate),
    .exit_gate    (exit_gate),
    .fault        (fault),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int chg_edge = 0;
  int ent_cyc = 0;
  int ent_cnt = 0;
  int ext_cnt = 0;
  int flt_cnt = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A traversal is a walk along the ring 00 -> a -> 11 -> b -> 00, where
  // entry uses a=10,b=01 and exit uses a=01,b=10. One step forward advances,
  // one step back retreats; anything else is a fault.
  function automatic logic [1:0] path(input int d, input int k);
    case (k % 4)
      0:       return 2'b00;
      1:       return d ? 2'b01 : 2'b10;
      2:       return 2'b11;
      default: return d ? 2'b10 : 2'b01;
    endcase
  endfunction

  bit m_s1o, m_s1i, m_s2o, m_s2i, m_fo, m_fi;
  bit [7:0] h_o, h_i;
  int mode = 0;   // 0 idle, 1 travelling, 2 faulted
  int dir = 0;
  int pos = 0;
  bit m_ent, m_ext, m_flt, m_busy;

  always @(posedge clk) begin
    logic [1:0] p;
    bit [7:0] mask;
    cyc++;
    m_ent = 0;
    m_ext = 0;
    m_flt = 0;
    if (!reset) begin
      m_s1o = 0; m_s1i = 0; m_s2o = 0; m_s2i = 0; m_fo = 0; m_fi = 0;
      h_o = 0; h_i = 0;
      mode = 0; pos = 0; dir = 0;
      m_busy = 0;
    end else begin
`ifdef PARKING_SENSOR_DEBOUNCE_EN
      p = {m_fo, m_fi};
`else
      p = {m_s2o, m_s2i};
`endif
      if (mode == 0) begin
        if (p == path(0, 1)) begin mode = 1; dir = 0; pos = 1; end
        else if (p == path(1, 1)) begin mode = 1; dir = 1; pos = 1; end
        else if (p != 2'b00) begin mode = 2; m_flt = 1; end
      end else if (mode == 1) begin
        if (p == path(dir, pos)) begin
        end else if (p == path(dir, pos + 1)) begin
          if (pos == 3) begin
            mode = 0;
            if (dir == 1) m_ext = 1; else m_ent = 1;
          end else pos++;
        end else if (p == path(dir, pos - 1)) begin
          if (pos == 1) mode = 0; else pos--;
        end else begin
          mode = 2; m_flt = 1;
        end
      end else if (p == 2'b00) begin
        mode = 0;
      end
      m_busy = (mode != 0);
`ifdef PARKING_SENSOR_DEBOUNCE_EN
      // Filtered bit flips once the last DB synchronized samples all disagree.
      h_o = {h_o[6:0], m_s2o};
      h_i = {h_i[6:0], m_s2i};
      mask = 8'((1 << DB) - 1);
      if ((h_o & mask) == (m_fo ? 8'h00 : mask)) m_fo = ~m_fo;
      if ((h_i & mask) == (m_fi ? 8'h00 : mask)) m_fi = ~m_fi;
`endif
      m_s2o = m_s1o; m_s2i = m_s1i;
      m_s1o = so;    m_s1i = si;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    check("entrance_gate", int'(entrance_gate), int'(m_ent));
    check("exit_gate", int'(exit_gate), int'(m_ext));
    check("fault", int'(fault), int'(m_flt));
    check("busy", int'(busy), int'(m_busy));
    if (entrance_gate === 1'b1) begin ent_cnt++; ent_cyc = cyc; end
    if (exit_gate === 1'b1) ext_cnt++;
    if (fault === 1'b1) flt_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(input bit o, input bit i, input int unsigned n);
    @(negedge clk);
    so = o;
    si = i;
    chg_edge = cyc + 1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic clear_counts();
    ent_cnt = 0; ext_cnt = 0; flt_cnt = 0; ent_cyc = 0;
  endtask

  task automatic check_counts(input string tag, input int e, input int x, input int f);
    check({tag, "_entrances"}, ent_cnt, e);
    check({tag, "_exits"}, ext_cnt, x);
    check({tag, "_faults"}, flt_cnt, f);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({entrance_gate, exit_gate, fault, busy}), 0);
    reset = 1'b1;
    hold(0, 0, 5);

    // Full entry.
    clear_counts();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    check_counts("entry", 1, 0, 0);
    check("entry_latency", ent_cyc - chg_edge, LAT);
    check("entry_busy_end", int'(busy), 0);

    // Full exit.
    clear_counts();
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10);
    check("exit_busy_mid", int'(busy), 1);
    hold(0, 0, 10);
    check_counts("exit", 0, 1, 0);
    check("exit_busy_end", int'(busy), 0);

    // Reversal back out the street side.
    clear_counts();
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check_counts("reverse", 0, 0, 0);
    check("reverse_busy_end", int'(busy), 0);

    // Inner-beam chatter while outer is blocked.
    hold(1, 0, 10);
    clear_counts();
    for (int k = 0; k < 20; k++) hold(1, (k % 2) == 0, 1);
    hold(1, 0, 6);
    check_counts("glitch", 0, 0, 0);
    check("glitch_busy", int'(busy), 1);
    hold(0, 0, 10);
    check("glitch_busy_end", int'(busy), 0);

    // Both beams at once.
    clear_counts();
    hold(1, 1, 10); hold(0, 1, 10);
    check("fault_held_busy", int'(busy), 1);
    hold(0, 0, 10);
    check_counts("both", 0, 0, 1);
    check("fault_busy_end", int'(busy), 0);

    // Reset in the middle of an entry.
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    check("pre_reset_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b0; so = 1'b0; si = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", int'({entrance_gate, exit_gate, fault, busy}), 0);
    reset = 1'b1;
    clear_counts();
    hold(0, 0, 20);
    check_counts("after_reset", 0, 0, 0);

    // Random raw traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    hold(0, 0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
